// File: rtl/pipeline_if_id.sv
// IF/ID pipeline register with stall/flush handling and HLT detection that freezes fetch.
// Optional performance counters are enabled by defining IFID_PERF_CNT_EN.
`timescale 1ns/1ps

module pipeline_if_id #(
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] if_instr_i,
    input  logic [15:0] if_pc_plus2_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [15:0] id_instr_o,
    output logic [15:0] id_pc_plus2_o,
    output logic        id_valid_o,
    output logic        pc_hold_o,
    output logic        halted_o
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StHaltPend = 2'd1;
    localparam logic [1:0] StHalted   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        case (state_q)
            StRun: begin
                if (flush_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    instr_d = if_instr_i;
                    pc_d    = if_pc_plus2_i;
                    valid_d = 1'b1;
                    if (if_instr_i[15:12] == HALT_OPCODE) begin
                        state_d = StHaltPend;
                    end
                end
            end
            StHaltPend: begin
                // Either way the HLT leaves ID; only a flush sends us back to fetching.
                if (flush_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = StRun;
                end else if (!stall_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = StHalted;
                end
            end
            StHalted: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            instr_q <= NOP_INSTR;
            pc_q    <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign id_instr_o    = instr_q;
    assign id_pc_plus2_o = pc_q;
    assign id_valid_o    = valid_q && (state_q != StHalted);
    assign pc_hold_o     = (state_q == StRun) ? stall_i : 1'b1;
    assign halted_o      = (state_q == StHalted);

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Flush takes precedence: a cycle with both high counts only as a flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != StHalted) begin
            if (flush_i) begin
                if (flush_cnt_q != 16'hFFFF) begin
                    flush_cnt_d = flush_cnt_q + 16'd1;
                end
            end else if (stall_i) begin
                if (stall_cnt_q != 16'hFFFF) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_if_id.sv
// Self-checking bench for pipeline_if_id against a behavioural model of the IF/ID rules.
`timescale 1ns/1ps

module tb_pipeline_if_id;

    logic        clk;
    logic        rst;
    logic [15:0] if_instr;
    logic [15:0] if_pc_plus2;
    logic        stall;
    logic        flush;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        id_valid;
    logic        pc_hold;
    logic        halted;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what sits in ID, whether that is a pending HLT, and whether the core is halted.
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;
    bit          m_hlt_in_id;
    bit          m_halted;
    int          m_scnt;
    int          m_fcnt;

    pipeline_if_id dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .if_instr_i   (if_instr),
        .if_pc_plus2_i(if_pc_plus2),
        .stall_i      (stall),
        .flush_i      (flush),
        .id_instr_o   (id_instr),
        .id_pc_plus2_o(id_pc_plus2),
        .id_valid_o   (id_valid),
        .pc_hold_o    (pc_hold),
        .halted_o     (halted)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_pc_hold();
        return (m_hlt_in_id || m_halted) ? 1'b1 : stall;
    endfunction

    task automatic set_in(input logic r, input logic [15:0] ins, input logic [15:0] pc,
                          input logic s, input logic f);
        rst         = r;
        if_instr    = ins;
        if_pc_plus2 = pc;
        stall       = s;
        flush       = f;
    endtask

    // Advance one clock edge and apply the same rules to the model; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_instr = 16'h0000; m_pc = 16'h0000; m_valid = 1'b0;
            m_hlt_in_id = 0; m_halted = 0; m_scnt = 0; m_fcnt = 0;
        end else if (!m_halted) begin
            if (flush) m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : m_fcnt;
            else if (stall) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : m_scnt;
            if (flush) begin
                m_instr = 16'h0000; m_valid = 1'b0; m_hlt_in_id = 0;
            end else if (!stall) begin
                if (m_hlt_in_id) begin
                    m_instr = 16'h0000; m_valid = 1'b0; m_hlt_in_id = 0; m_halted = 1;
                end else begin
                    m_instr = if_instr; m_pc = if_pc_plus2; m_valid = 1'b1;
                    m_hlt_in_id = (if_instr[15:12] == 4'hF);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1'b1, 16'hBEEF, 16'h1111, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (id_instr !== 16'h0000) $display("FAIL reset_instr: got %h expected 0000", id_instr);
        else n_pass++;
        n_checks++;
        if (id_pc_plus2 !== 16'h0000) $display("FAIL reset_pc: got %h expected 0000", id_pc_plus2);
        else n_pass++;
        n_checks++;
        if (id_valid !== 1'b0 || halted !== 1'b0 || pc_hold !== 1'b0)
            $display("FAIL reset_flags: got valid=%b halted=%b pc_hold=%b expected 0/0/0",
                     id_valid, halted, pc_hold);
        else n_pass++;
`ifdef IFID_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'h0 || flush_cnt !== 16'h0)
            $display("FAIL reset_cnt: got %h/%h expected 0000/0000", stall_cnt, flush_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_capture();
        set_in(1'b0, 16'h1234, 16'h0010, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (id_instr !== 16'h1234 || id_pc_plus2 !== 16'h0010 || id_valid !== 1'b1)
            $display("FAIL capture: got %h/%h/%b expected 1234/0010/1",
                     id_instr, id_pc_plus2, id_valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        set_in(1'b0, 16'hA5A5, 16'h0020, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 16'(i * 16'h1111 + 16'h0101), 16'h0030, 1'b1, 1'b0);
            #1;
            n_checks++;
            if (pc_hold !== 1'b1) $display("FAIL stall_pc_hold: got %b expected 1", pc_hold);
            else n_pass++;
            tick();
            n_checks++;
            if (id_instr !== 16'hA5A5 || id_pc_plus2 !== 16'h0020 || id_valid !== 1'b1)
                $display("FAIL stall_hold: got %h/%h/%b expected a5a5/0020/1",
                         id_instr, id_pc_plus2, id_valid);
            else n_pass++;
        end
`ifdef IFID_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 16'd3) $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_flush_stall();
        set_in(1'b0, 16'h2222, 16'h0040, 1'b1, 1'b1);
        tick();
        n_checks++;
        if (id_instr !== 16'h0000 || id_valid !== 1'b0 || id_pc_plus2 !== 16'h0020)
            $display("FAIL flush_stall: got %h/%b/%h expected 0000/0/0020",
                     id_instr, id_valid, id_pc_plus2);
        else n_pass++;
`ifdef IFID_PERF_CNT_EN
        n_checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3)
            $display("FAIL flush_stall_cnt: got %0d/%0d expected 1/3", flush_cnt, stall_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_halt();
        set_in(1'b0, 16'hF000, 16'h0050, 1'b0, 1'b0);
        tick();
        #1;
        n_checks++;
        if (pc_hold !== 1'b1 || halted !== 1'b0 || id_valid !== 1'b1)
            $display("FAIL halt_pend: got pc_hold=%b halted=%b valid=%b expected 1/0/1",
                     pc_hold, halted, id_valid);
        else n_pass++;
        set_in(1'b0, 16'h1357, 16'h0052, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (id_valid !== 1'b0 || halted !== 1'b1 || id_instr !== 16'h0000)
            $display("FAIL halt_enter: got valid=%b halted=%b instr=%h expected 0/1/0000",
                     id_valid, halted, id_instr);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, 16'($urandom), 16'($urandom), 1'(i % 3 == 0), 1'(i % 2));
            tick();
            n_checks++;
            if (halted !== 1'b1 || id_valid !== 1'b0 || pc_hold !== 1'b1)
                $display("FAIL halt_sticky: got halted=%b valid=%b pc_hold=%b expected 1/0/1",
                         halted, id_valid, pc_hold);
            else n_pass++;
        end
        set_in(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (halted !== 1'b0 || pc_hold !== 1'b0)
            $display("FAIL halt_reset: got halted=%b pc_hold=%b expected 0/0", halted, pc_hold);
        else n_pass++;
    endtask

    task automatic test_wrong_path_halt();
        set_in(1'b0, 16'hF123, 16'h0060, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 16'h4444, 16'h0062, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (halted !== 1'b0 || id_valid !== 1'b0 || pc_hold !== 1'b0)
            $display("FAIL wrong_path_flush: got halted=%b valid=%b pc_hold=%b expected 0/0/0",
                     halted, id_valid, pc_hold);
        else n_pass++;
        set_in(1'b0, 16'h3333, 16'h0064, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (id_instr !== 16'h3333 || id_valid !== 1'b1 || halted !== 1'b0)
            $display("FAIL wrong_path_resume: got %h/%b/%b expected 3333/1/0",
                     id_instr, id_valid, halted);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
            set_in(1'($urandom_range(0, 49) == 0), ins, 16'($urandom),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
            #1;
            n_checks++;
            if (pc_hold !== exp_pc_hold())
                $display("FAIL rand_pc_hold[%0d]: got %b expected %b", i, pc_hold, exp_pc_hold());
            else n_pass++;
            tick();
            n_checks++;
            if (id_instr !== m_instr || id_pc_plus2 !== m_pc || id_valid !== m_valid ||
                halted !== 1'(m_halted))
                $display("FAIL rand_state[%0d]: got %h/%h/%b/%b expected %h/%h/%b/%b", i,
                         id_instr, id_pc_plus2, id_valid, halted,
                         m_instr, m_pc, m_valid, m_halted);
            else n_pass++;
`ifdef IFID_PERF_CNT_EN
            n_checks++;
            if (stall_cnt !== 16'(m_scnt) || flush_cnt !== 16'(m_fcnt))
                $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i,
                         stall_cnt, flush_cnt, m_scnt, m_fcnt);
            else n_pass++;
`endif
        end
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic test_saturation();
        set_in(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) tick();
        n_checks++;
        if (stall_cnt !== 16'hFFFF) $display("FAIL stall_sat: got %h expected ffff", stall_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        set_in(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        test_reset();
        test_capture();
        test_stall();
        test_flush_stall();
        test_halt();
        test_wrong_path_halt();
        test_random();
`ifdef IFID_PERF_CNT_EN
        test_saturation();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
